fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction prefetch stage between the instruction ROM and the IF/ID pipe register.
- Drives the ROM address and captures the ROM's 1-cycle-latency read data into a small FIFO of {instruction, pc} entries.
- Presents the FIFO head to decode with a valid/ready handshake.
- On a taken branch, flushes all queued and in-flight fetches and restarts from the redirect target.

Parameters:
- N, 32, instruction and PC width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- AW, 12, ROM address width; rom_address_o = fetch_pc[AW-1:0].
- RESET_PC, 0, fetch PC loaded at reset.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  asynchronous, active-low reset.
- rom_address_o  out  AW  ROM read address, combinational from fetch_pc.
- rom_data_i  in  N  ROM data; valid one cycle after the issuing address.
- redirect_i  in  1  taken branch or flush request from the PC controller.
- redirect_pc_i  in  N  new fetch PC, sampled when redirect_i=1.
- ready_i  in  1  decode accepts the head entry this cycle.
- valid_o  out  1  FIFO non-empty.
- instruction_o  out  N  head instruction.
- pc_o  out  N  PC of the head instruction.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (RST=0, async):
  - fetch_pc=RESET_PC, inflight=0, count=0, read/write pointers=0.
  - valid_o=0, instruction_o=0, pc_o=0, count_o=0.
  - rom_address_o=RESET_PC[AW-1:0].
- Issue:
  - issue = !redirect_i && (count + inflight < DEPTH).
  - On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1 (mod 2^N).
  - Otherwise inflight<=0 and fetch_pc holds.
  - Pops never grant same-cycle credit; this conservative credit rule makes overflow impossible.
- Response:
  - When inflight=1 and redirect_i=0, push {rom_data_i, inflight_pc} at the write pointer.
  - The ROM address holds whenever no issue occurs.
- Pop:
  - When valid_o && ready_i && !redirect_i, the read pointer advances.
  - Push and pop in the same cycle leave count unchanged.
- Output timing:
  - Head outputs are read from the FIFO register array (registered, no bypass).
  - Latency from address issue to valid_o is 2 cycles.
  - First valid_o after reset release is in cycle 2 with pc_o=RESET_PC.
- Throughput: 1 instruction/cycle sustained with ready_i=1 (steady state count=1, inflight=1).
- Redirect (redirect_i=1), all applied next edge:
  - count<=0, both pointers<=0, inflight<=0.
  - Any response arriving this cycle is discarded; any pop this cycle is ignored.
  - fetch_pc<=redirect_pc_i; no issue this cycle.
  - Next cycle: issue from redirect_pc_i.
  - First redirected instruction shows valid_o 2 cycles after that issue.
- Back-to-back redirects: the last one wins.
- Pointers wrap modulo DEPTH.
- instruction_o and pc_o hold their last head contents when valid_o=0; decode must qualify them with valid_o.
- Async reset mid-burst: everything clears immediately; no partial entry survives.

Optional Feature:
- Macro FETCH_QUEUE_STATS_EN.
- Defined:
  - Adds output flush_count_o[15:0]: increments each cycle redirect_i=1.
  - Adds output stall_count_o[15:0]: increments each cycle valid_o=1 && ready_i=0.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, release, ROM[i]=32'hA000_0000+i, ready_i=1 -> rom_address_o=0,1,2,... each cycle; valid_o first high in cycle 2 with pc_o=0 and instruction_o=A000_0000; then pc_o=1,2,3 on consecutive cycles with no bubbles.
- ready_i=0 from reset -> count_o reaches 4; rom_address_o stops at 4; valid_o=1, pc_o=0 held. Set ready_i=1 -> pc_o 0,1,2,3 then 4 with no gap or duplicate.
- Full queue, redirect_i=1 with redirect_pc_i=32'h40 -> next cycle count_o=0, valid_o=0, rom_address_o=12'h040; valid_o with pc_o=32'h40 two cycles later.
- Redirect in the same cycle an inflight response returns (PC 7) -> PC 7 never appears on pc_o; the first pc_o after redirect equals redirect_pc_i.
- fetch_pc=32'hFFFF_FFFF, no stall -> following entry has pc_o=0 and rom_address_o=0.
- Async RST low mid-stream with count=3 -> valid_o=0, count_o=0 immediately without a clock edge. With FETCH_QUEUE_STATS_EN: 3 redirects plus 5 stall cycles -> flush_count_o=3, stall_count_o=5.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Bundles the ROM, redirect and decode-side signals of the instruction fetch queue.
// Stats ports exist only when FETCH_QUEUE_STATS_EN is defined.
`timescale 1ns/1ps

interface fetch_queue_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 12
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0] rom_address_o;
  logic [N-1:0]  rom_data_i;
  logic          redirect_i;
  logic [N-1:0]  redirect_pc_i;
  logic          ready_i;
  logic          valid_o;
  logic [N-1:0]  instruction_o;
  logic [N-1:0]  pc_o;
  logic [CW-1:0] count_o;
`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0]   flush_count_o;
  logic [15:0]   stall_count_o;

  modport slave (
    input  rom_data_i, redirect_i, redirect_pc_i, ready_i,
    output rom_address_o, valid_o, instruction_o, pc_o, count_o,
           flush_count_o, stall_count_o
  );

  modport master (
    output rom_data_i, redirect_i, redirect_pc_i, ready_i,
    input  rom_address_o, valid_o, instruction_o, pc_o, count_o,
           flush_count_o, stall_count_o
  );
`else
  modport slave (
    input  rom_data_i, redirect_i, redirect_pc_i, ready_i,
    output rom_address_o, valid_o, instruction_o, pc_o, count_o
  );

  modport master (
    output rom_data_i, redirect_i, redirect_pc_i, ready_i,
    input  rom_address_o, valid_o, instruction_o, pc_o, count_o
  );
`endif
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues ROM reads, queues {instruction, pc} and flushes on redirect.
// Optional macro FETCH_QUEUE_STATS_EN adds saturating flush and stall counters.
`timescale 1ns/1ps

module fetch_queue #(
  parameter int unsigned   N        = 32,
  parameter int unsigned   DEPTH    = 4,
  parameter int unsigned   AW       = 12,
  parameter logic [N-1:0]  RESET_PC = '0
) (
  input  logic         CLK,
  input  logic         RST,
  fetch_queue_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [N-1:0] instr;
    logic [N-1:0] pc;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [N-1:0]  fetch_pc_q, fetch_pc_d;
  logic [N-1:0]  inflight_pc_q, inflight_pc_d;
  logic          inflight_q, inflight_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [CW:0]   occupancy;
  logic          valid;
  logic          issue;
  logic          push;
  logic          pop;
  logic [PW-1:0] head_idx;

  // Credit counts the in-flight read; pops never free a slot in the same cycle.
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign valid     = (count_q != '0);
  assign issue     = !bus.redirect_i && (occupancy < DEPTH_W);
  assign push      = inflight_q && !bus.redirect_i;
  assign pop       = valid && bus.ready_i && !bus.redirect_i;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    if (bus.redirect_i) begin
      fetch_pc_d = bus.redirect_pc_i;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 1'b1;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)
        count_d = count_q + 1'b1;
      else if (!push && pop)
        count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= '{instr: bus.rom_data_i, pc: inflight_pc_q};
    end
  end

  // When empty, show the slot behind the read pointer so the last head stays visible.
  assign head_idx = valid ? rd_ptr_q : rd_ptr_q - 1'b1;

  assign bus.rom_address_o = fetch_pc_q[AW-1:0];
  assign bus.valid_o       = valid;
  assign bus.instruction_o = mem_q[head_idx].instr;
  assign bus.pc_o          = mem_q[head_idx].pc;
  assign bus.count_o       = count_q;

`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] flush_count_q;
  logic [15:0] stall_count_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      flush_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (bus.redirect_i && flush_count_q != 16'hFFFF)
        flush_count_q <= flush_count_q + 1'b1;
      if (valid && !bus.ready_i && stall_count_q != 16'hFFFF)
        stall_count_q <= stall_count_q + 1'b1;
    end
  end

  assign bus.flush_count_o = flush_count_q;
  assign bus.stall_count_o = stall_count_q;
`endif

endmodule
